// File: rtl/measure_sequencer.sv
// Sequences a set of measurement units and a transmitter: start the selected units,
// wait for them to finish, kick the transmitter, optionally re-arm.
module measure_sequencer #(
    parameter int N_UNITS      = 2,
    parameter int ACK_TIMEOUT  = 16,
    parameter int MEAS_TIMEOUT = 1000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    input  logic [N_UNITS-1:0] cmd_mask,
    input  logic               continuous,
    input  logic               abort,
    input  logic [N_UNITS-1:0] unit_busy,
    output logic [N_UNITS-1:0] unit_start,
    input  logic               tx_busy,
    output logic               tx_start,
    output logic               ready,
    output logic [2:0]         state_out,
    output logic [N_UNITS-1:0] active_mask,
    output logic               err_ack,
    output logic               err_meas,
    output logic [N_UNITS-1:0] err_units,
    output logic [15:0]        cycle_count
);

    localparam int TMO_MAX = (ACK_TIMEOUT > MEAS_TIMEOUT) ? ACK_TIMEOUT : MEAS_TIMEOUT;
    localparam int TMO_W   = $clog2(TMO_MAX) + 1;

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_START_MEAS = 3'd1;
    localparam logic [2:0] S_WAIT_MEAS  = 3'd2;
    localparam logic [2:0] S_START_TX   = 3'd3;
    localparam logic [2:0] S_WAIT_TX    = 3'd4;

    logic [2:0]         state;
    logic [N_UNITS-1:0] acked;
    logic [TMO_W-1:0]   tmo_cnt;

    logic [2:0]         state_nxt;
    logic [N_UNITS-1:0] acked_nxt;
    logic [TMO_W-1:0]   tmo_cnt_nxt;
    logic [N_UNITS-1:0] unit_start_nxt;
    logic               tx_start_nxt;
    logic [N_UNITS-1:0] active_mask_nxt;
    logic               err_ack_nxt;
    logic               err_meas_nxt;
    logic [N_UNITS-1:0] err_units_nxt;
    logic [15:0]        cycle_count_nxt;
    logic [N_UNITS-1:0] seen;
    logic               ack_expired;
    logic               meas_expired;

    assign ack_expired  = (tmo_cnt == TMO_W'(ACK_TIMEOUT - 1));
    assign meas_expired = (tmo_cnt == TMO_W'(MEAS_TIMEOUT - 1));
    assign state_out    = state;

    always_comb begin
        state_nxt       = state;
        acked_nxt       = acked;
        unit_start_nxt  = '0;
        tx_start_nxt    = 1'b0;
        active_mask_nxt = active_mask;
        err_ack_nxt     = err_ack;
        err_meas_nxt    = err_meas;
        err_units_nxt   = err_units;
        cycle_count_nxt = cycle_count;
        tmo_cnt_nxt     = tmo_cnt + TMO_W'(1);
        // Acknowledge is sticky per unit; busy on unselected units never counts.
        seen            = acked | (unit_busy & active_mask);

        case (state)
            S_IDLE: begin
                if (cmd_valid && (cmd_mask != '0)) begin
                    state_nxt       = S_START_MEAS;
                    active_mask_nxt = cmd_mask;
                    acked_nxt       = '0;
                    unit_start_nxt  = cmd_mask;
                    err_ack_nxt     = 1'b0;
                    err_meas_nxt    = 1'b0;
                    err_units_nxt   = '0;
                    cycle_count_nxt = '0;
                end
            end
            S_START_MEAS: begin
                acked_nxt = seen;
                if (seen == active_mask) begin
                    state_nxt = S_WAIT_MEAS;
                end else if (ack_expired) begin
                    state_nxt     = S_IDLE;
                    err_ack_nxt   = 1'b1;
                    err_units_nxt = active_mask & ~seen;
                end else begin
                    unit_start_nxt = active_mask & ~seen;
                end
            end
            S_WAIT_MEAS: begin
                if ((unit_busy & active_mask) == '0) begin
                    state_nxt    = S_START_TX;
                    tx_start_nxt = 1'b1;
                end else if (meas_expired) begin
                    state_nxt     = S_IDLE;
                    err_meas_nxt  = 1'b1;
                    err_units_nxt = unit_busy & active_mask;
                end
            end
            S_START_TX: begin
                if (tx_busy) begin
                    state_nxt = S_WAIT_TX;
                end else if (ack_expired) begin
                    state_nxt     = S_IDLE;
                    err_ack_nxt   = 1'b1;
                    err_units_nxt = '0;
                end else begin
                    tx_start_nxt = 1'b1;
                end
            end
            S_WAIT_TX: begin
                if (!tx_busy) begin
                    cycle_count_nxt = cycle_count + 16'd1;
                    if (continuous) begin
                        state_nxt      = S_START_MEAS;
                        acked_nxt      = '0;
                        unit_start_nxt = active_mask;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // Abort overrides every transition above but leaves error and count history intact.
        if (abort && (state != S_IDLE)) begin
            state_nxt       = S_IDLE;
            unit_start_nxt  = '0;
            tx_start_nxt    = 1'b0;
            err_ack_nxt     = err_ack;
            err_meas_nxt    = err_meas;
            err_units_nxt   = err_units;
            cycle_count_nxt = cycle_count;
        end

        if ((state_nxt != state) || (state_nxt == S_IDLE)) begin
            tmo_cnt_nxt = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            acked       <= '0;
            tmo_cnt     <= '0;
            unit_start  <= '0;
            tx_start    <= 1'b0;
            ready       <= 1'b1;
            active_mask <= '0;
            err_ack     <= 1'b0;
            err_meas    <= 1'b0;
            err_units   <= '0;
            cycle_count <= '0;
        end else begin
            state       <= state_nxt;
            acked       <= acked_nxt;
            tmo_cnt     <= tmo_cnt_nxt;
            unit_start  <= unit_start_nxt;
            tx_start    <= tx_start_nxt;
            ready       <= (state_nxt == S_IDLE);
            active_mask <= active_mask_nxt;
            err_ack     <= err_ack_nxt;
            err_meas    <= err_meas_nxt;
            err_units   <= err_units_nxt;
            cycle_count <= cycle_count_nxt;
        end
    end

endmodule

// File: tb/tb_measure_sequencer.sv
// Directed bench for measure_sequencer with hand-computed expectations, 2 units, short timeouts.
module tb_measure_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic [1:0] cmd_mask;
    logic       continuous;
    logic       abort;
    logic [1:0] unit_busy;
    logic [1:0] unit_start;
    logic       tx_busy;
    logic       tx_start;
    logic       ready;
    logic [2:0] state_out;
    logic [1:0] active_mask;
    logic       err_ack;
    logic       err_meas;
    logic [1:0] err_units;
    logic [15:0] cycle_count;

    int n_chk = 0;
    int n_err = 0;
    int reentries = 0;

    measure_sequencer #(
        .N_UNITS(2),
        .ACK_TIMEOUT(16),
        .MEAS_TIMEOUT(100)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cmd_valid(cmd_valid),
        .cmd_mask(cmd_mask),
        .continuous(continuous),
        .abort(abort),
        .unit_busy(unit_busy),
        .unit_start(unit_start),
        .tx_busy(tx_busy),
        .tx_start(tx_start),
        .ready(ready),
        .state_out(state_out),
        .active_mask(active_mask),
        .err_ack(err_ack),
        .err_meas(err_meas),
        .err_units(err_units),
        .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_reset(input string tag);
        chk({tag, ".state"}, 32'(state_out), 0);
        chk({tag, ".ready"}, 32'(ready), 1);
        chk({tag, ".ustart"}, 32'(unit_start), 0);
        chk({tag, ".txs"}, 32'(tx_start), 0);
        chk({tag, ".mask"}, 32'(active_mask), 0);
        chk({tag, ".eack"}, 32'(err_ack), 0);
        chk({tag, ".emeas"}, 32'(err_meas), 0);
        chk({tag, ".eunits"}, 32'(err_units), 0);
        chk({tag, ".cnt"}, 32'(cycle_count), 0);
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_mask = 2'b00; continuous = 1'b0;
        abort = 1'b0; unit_busy = 2'b00; tx_busy = 1'b0;
        tick(); tick();
        chk_idle_reset("rst");
        rst = 1'b0;

        // Full cycle, both units
        cmd_valid = 1'b1; cmd_mask = 2'b11;
        tick();
        chk("t1.state_sm", 32'(state_out), 1);
        chk("t1.ustart", 32'(unit_start), 32'b11);
        chk("t1.mask", 32'(active_mask), 32'b11);
        chk("t1.ready", 32'(ready), 0);
        cmd_valid = 1'b0;
        tick();
        chk("t1.ustart_hold", 32'(unit_start), 32'b11);
        unit_busy = 2'b11;
        tick();
        chk("t1.state_wm", 32'(state_out), 2);
        chk("t1.ustart_drop", 32'(unit_start), 0);
        cmd_valid = 1'b1; cmd_mask = 2'b01;
        tick();
        chk("t1.cmd_ignored", 32'(active_mask), 32'b11);
        cmd_valid = 1'b0;
        repeat (8) tick();
        chk("t1.still_wm", 32'(state_out), 2);
        unit_busy = 2'b00;
        tick();
        chk("t1.state_stx", 32'(state_out), 3);
        chk("t1.txs_on", 32'(tx_start), 1);
        tick();
        chk("t1.txs_hold", 32'(tx_start), 1);
        tx_busy = 1'b1;
        tick();
        chk("t1.state_wtx", 32'(state_out), 4);
        chk("t1.txs_off", 32'(tx_start), 0);
        tick(); tick();
        chk("t1.still_wtx", 32'(state_out), 4);
        tx_busy = 1'b0;
        tick();
        chk("t1.state_idle", 32'(state_out), 0);
        chk("t1.ready_end", 32'(ready), 1);
        chk("t1.cnt", 32'(cycle_count), 1);
        chk("t1.txs_end", 32'(tx_start), 0);

        // Zero mask ignored
        cmd_valid = 1'b1; cmd_mask = 2'b00;
        tick();
        chk("zmask.state", 32'(state_out), 0);
        chk("zmask.mask", 32'(active_mask), 32'b11);

        // Per-unit sticky ack, then abort in START_TX
        cmd_mask = 2'b11;
        tick();
        cmd_valid = 1'b0;
        unit_busy = 2'b01;
        tick();
        chk("pu.state", 32'(state_out), 1);
        chk("pu.ustart", 32'(unit_start), 32'b10);
        unit_busy = 2'b10;
        tick();
        chk("pu.state_wm", 32'(state_out), 2);
        chk("pu.ustart0", 32'(unit_start), 0);
        unit_busy = 2'b00;
        tick();
        chk("pu.state_stx", 32'(state_out), 3);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_tx.state", 32'(state_out), 0);
        chk("ab_tx.txs", 32'(tx_start), 0);
        chk("ab_tx.eack", 32'(err_ack), 0);
        chk("ab_tx.cnt", 32'(cycle_count), 0);

        // Ack timeout, unselected busy ignored
        cmd_valid = 1'b1; cmd_mask = 2'b01;
        tick();
        chk("to.ustart", 32'(unit_start), 32'b01);
        cmd_valid = 1'b0; unit_busy = 2'b10;
        repeat (15) tick();
        chk("to.state_pre", 32'(state_out), 1);
        chk("to.ustart_pre", 32'(unit_start), 32'b01);
        tick();
        chk("to.state", 32'(state_out), 0);
        chk("to.eack", 32'(err_ack), 1);
        chk("to.eunits", 32'(err_units), 32'b01);
        chk("to.ustart", 32'(unit_start), 0);
        unit_busy = 2'b00;

        // Measurement timeout; busy already high on entry counts as ack
        cmd_valid = 1'b1; cmd_mask = 2'b11; unit_busy = 2'b11;
        tick();
        chk("mt.eack_clr", 32'(err_ack), 0);
        chk("mt.eunits_clr", 32'(err_units), 0);
        cmd_valid = 1'b0;
        tick();
        chk("mt.state_wm", 32'(state_out), 2);
        unit_busy = 2'b10;
        repeat (99) tick();
        chk("mt.state_pre", 32'(state_out), 2);
        chk("mt.emeas_pre", 32'(err_meas), 0);
        tick();
        chk("mt.state", 32'(state_out), 0);
        chk("mt.emeas", 32'(err_meas), 1);
        chk("mt.eunits", 32'(err_units), 32'b10);
        unit_busy = 2'b00;

        // Transmitter ack timeout
        cmd_valid = 1'b1; cmd_mask = 2'b01;
        tick();
        cmd_valid = 1'b0; unit_busy = 2'b01;
        tick();
        unit_busy = 2'b00;
        tick();
        chk("txto.state_stx", 32'(state_out), 3);
        repeat (15) tick();
        chk("txto.txs_pre", 32'(tx_start), 1);
        tick();
        chk("txto.state", 32'(state_out), 0);
        chk("txto.eack", 32'(err_ack), 1);
        chk("txto.eunits", 32'(err_units), 0);
        chk("txto.emeas", 32'(err_meas), 0);
        chk("txto.txs", 32'(tx_start), 0);

        // Continuous: three cycles, two re-entries
        cmd_valid = 1'b1; cmd_mask = 2'b01; continuous = 1'b1;
        tick();
        cmd_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            unit_busy = 2'b01;
            tick();
            unit_busy = 2'b00;
            tick();
            tx_busy = 1'b1;
            tick();
            tx_busy = 1'b0;
            if (k == 2) continuous = 1'b0;
            tick();
            chk("cont.cnt", 32'(cycle_count), 32'(k + 1));
            if (state_out == 3'd1) reentries++;
            if (k == 0) begin
                chk("cont.ustart", 32'(unit_start), 32'b01);
                tick();
                chk("cont.ack_clr", 32'(state_out), 1);
            end
        end
        chk("cont.reentries", 32'(reentries), 2);
        chk("cont.final", 32'(state_out), 0);
        chk("cont.ready", 32'(ready), 1);

        // Abort in WAIT_MEAS, then reset during START_TX
        cmd_valid = 1'b1; cmd_mask = 2'b11; unit_busy = 2'b11;
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("ab_wm.state_pre", 32'(state_out), 2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_wm.state", 32'(state_out), 0);
        chk("ab_wm.ustart", 32'(unit_start), 0);
        chk("ab_wm.eack", 32'(err_ack), 0);
        chk("ab_wm.emeas", 32'(err_meas), 0);
        unit_busy = 2'b00;
        cmd_valid = 1'b1; cmd_mask = 2'b01;
        tick();
        cmd_valid = 1'b0; unit_busy = 2'b01;
        tick();
        unit_busy = 2'b00;
        tick();
        chk("rs.state_stx", 32'(state_out), 3);
        rst = 1'b1;
        #1;
        chk_idle_reset("rs_async");
        rst = 1'b0;
        cmd_valid = 1'b1; cmd_mask = 2'b10;
        tick();
        chk("rs.first_cmd", 32'(state_out), 1);
        chk("rs.first_mask", 32'(active_mask), 32'b10);
        cmd_valid = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("rs.abort_idle", 32'(state_out), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/measure_sequencer.md
MEASURE_SEQUENCER -- requirements
Module: measure_sequencer

Interface
REQ-001 SHALL have parameter N_UNITS, default 2, giving the number of measurement units sequenced (1..8).
REQ-002 SHALL have parameter ACK_TIMEOUT, default 16, giving the cycles allowed for a start to be acknowledged by busy.
REQ-003 SHALL have parameter MEAS_TIMEOUT, default 1000000, giving the cycles allowed for all selected units to finish.
REQ-004 SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port cmd_valid, input, 1 bit: command request.
REQ-007 SHALL have port cmd_mask, input, N_UNITS bits: units to run.
REQ-008 SHALL have port continuous, input, 1 bit: re-arm after each transmit.
REQ-009 SHALL have port abort, input, 1 bit: return to idle.
REQ-010 SHALL have port unit_busy, input, N_UNITS bits: per-unit busy.
REQ-011 SHALL have port unit_start, output, N_UNITS bits: per-unit start.
REQ-012 SHALL have port tx_busy, input, 1 bit: transmitter busy.
REQ-013 SHALL have port tx_start, output, 1 bit: transmitter start.
REQ-014 SHALL have port ready, output, 1 bit: high in IDLE.
REQ-015 SHALL have port state_out, output, 3 bits: IDLE=0, START_MEAS=1, WAIT_MEAS=2, START_TX=3, WAIT_TX=4.
REQ-016 SHALL have port active_mask, output, N_UNITS bits: latched mask.
REQ-017 SHALL have port err_ack, output, 1 bit: sticky acknowledge-timeout flag.
REQ-018 SHALL have port err_meas, output, 1 bit: sticky measurement-timeout flag.
REQ-019 SHALL have port err_units, output, N_UNITS bits: offending units.
REQ-020 SHALL have port cycle_count, output, 16 bits: completed cycles, wraps at 0xFFFF->0.

Function
REQ-021 SHALL register all outputs; no combinational input-to-output path.
REQ-022 IDLE: cmd_valid=1 with cmd_mask!=0 latches active_mask, clears err_ack/err_meas/err_units/cycle_count, enters START_MEAS next edge; unit_start rises one cycle after acceptance.
REQ-023 IDLE: cmd_valid with cmd_mask=0 ignored, no state change; cmd_valid outside IDLE ignored.
REQ-024 START_MEAS: unit_start[i]=active_mask[i] until unit i seen busy (per-unit sticky ack), then unit_start[i] drops next cycle.
REQ-025 START_MEAS: all selected units acked -> WAIT_MEAS; busy on unselected units ignored.
REQ-026 START_MEAS: ACK_TIMEOUT cycles without full ack -> err_ack=1, err_units=unacked selected units, all starts 0, IDLE.
REQ-027 WAIT_MEAS: all starts 0; (unit_busy & active_mask)==0 -> START_TX.
REQ-028 WAIT_MEAS: MEAS_TIMEOUT cycles elapsed -> err_meas=1, err_units=still-busy selected units, IDLE.
REQ-029 START_TX: tx_start=1 until tx_busy=1 -> WAIT_TX; ACK_TIMEOUT without tx_busy -> err_ack=1, err_units=0, IDLE.
REQ-030 WAIT_TX: tx_start=0; tx_busy=0 -> cycle_count+1; continuous=1 -> START_MEAS with same active_mask, ack state cleared; else IDLE.
REQ-031 Timeout counter SHALL reset on every state entry; counter width = clog2 of the larger timeout plus 1.
REQ-032 abort=1 in any non-IDLE state -> IDLE next edge, all starts 0, error flags unchanged; abort has priority over every other transition.
REQ-033 Busy already high on START_MEAS entry counts as acknowledge.

Reset
REQ-034 rst=1 SHALL immediately force IDLE, unit_start=0, tx_start=0, ready=1, state_out=0, active_mask=0, err_ack=0, err_meas=0, err_units=0, cycle_count=0, including mid-operation.
REQ-035 After rst deasserts, first command SHALL be accepted on the first rising edge.

Verification
REQ-036 N_UNITS=2, cmd_mask=2'b11, busy both 2 cycles after start, low 10 later, tx_busy 3 cycles -> starts drop on ack, tx_start once, cycle_count=1, ready=1.
REQ-037 cmd_mask=2'b01, unit_busy[0] never rises -> after 16 cycles err_ack=1, err_units=2'b01, IDLE.
REQ-038 MEAS_TIMEOUT=100, unit 1 busy stuck high -> err_meas=1, err_units=2'b10 at cycle 100 of WAIT_MEAS.
REQ-039 continuous=1 for 3 cycles then 0 -> cycle_count=3, START_MEAS re-entered twice, final IDLE.
REQ-040 abort during WAIT_MEAS, then rst pulse during START_TX -> IDLE next edge, tx_start=0, no error flags; all outputs at reset values immediately.
